// File: rtl/vga_fb_reader.sv
// rtl/vga_fb_reader.sv - VGA scan-out engine reading a byte framebuffer
// Produces sync/de/greyscale pixels with one pixel of registered latency.
module vga_fb_reader #(
   parameter int CLK_DIV    = 2,
   parameter int FB_BASE    = 256,
   parameter int IMG_W      = 16,
   parameter int IMG_H      = 16,
   parameter int SCALE_LOG2 = 3,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [31:0] rdvga,
   output logic [31:0] avga,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic        frame_start,
   output logic [9:0]  hcount,
   output logic [9:0]  vcount
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [DIV_W-1:0] div;
   logic             pix_tick;
   logic             h_wrap;
   logic             v_wrap;
   logic             visible;
   logic             in_img;
   logic [31:0]      fx;
   logic [31:0]      fy;
   logic [7:0]       pix;
   logic             unused_rdvga;

   assign unused_rdvga = &{1'b0, rdvga[31:8]};

   assign pix_tick = en && (div == DIV_LAST);
   assign h_wrap   = (hcount == 10'(H_TOTAL - 1));
   assign v_wrap   = (vcount == 10'(V_TOTAL - 1));
   assign visible  = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));

   // Outside the image the address parks at the base so memory is never read out of range.
   assign fx     = 32'(hcount) >> SCALE_LOG2;
   assign fy     = 32'(vcount) >> SCALE_LOG2;
   assign in_img = (fx < 32'(IMG_W)) && (fy < 32'(IMG_H)) && visible;
   assign avga   = in_img ? (32'(FB_BASE) + fy * 32'(IMG_W) + fx) : 32'(FB_BASE);

   assign r = pix;
   assign g = pix;
   assign b = pix;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
      end else if (en) begin
         div <= pix_tick ? '0 : div + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount <= '0;
         vcount <= '0;
      end else if (pix_tick) begin
         hcount <= h_wrap ? 10'd0 : hcount + 10'd1;
         if (h_wrap) begin
            vcount <= v_wrap ? 10'd0 : vcount + 10'd1;
         end
      end
   end

   // frame_start is rewritten every clock so it stays a single-clock pulse even if en drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         de          <= 1'b0;
         pix         <= 8'd0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= pix_tick && h_wrap && v_wrap;
         if (pix_tick) begin
            hsync <= !((hcount >= HS_START) && (hcount < HS_END));
            vsync <= !((vcount >= VS_START) && (vcount < VS_END));
            de    <= visible;
            pix   <= in_img ? rdvga[7:0] : 8'd0;
         end
      end
   end

endmodule

// File: doc/vga_fb_reader.md
Name: vga_fb_reader

Overview:
- Scan-out engine for the VGA read port of the byte-addressed data memory.
- Generates 640x480@60 VGA timing from the system clock.
- Drives the framebuffer read address avga and consumes the byte returned combinationally on rdvga.
- Emits registered sync, data-enable and 8-bit greyscale RGB to the display pins. The CPU writes pixels through the normal store path; this block only reads.

Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz -> 25 MHz pixel rate); >=1
- FB_BASE, 256, byte address of framebuffer pixel (0,0)
- IMG_W, 16, framebuffer width in bytes/pixels
- IMG_H, 16, framebuffer height in rows
- SCALE_LOG2, 3, each framebuffer pixel drawn as 2^SCALE_LOG2 square screen pixels
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable; 0 freezes all counters and outputs
- rdvga  in  32  byte from memory at avga, combinational, bits [7:0] used
- avga  out  32  framebuffer read address
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- de  out  1  display enable (visible pixel)
- r, g, b  out  8 each  pixel colour
- frame_start  out  1  one-clk pulse when scan returns to (0,0)
- hcount  out  10  current horizontal counter
- vcount  out  10  current vertical counter

Behaviour:
- Reset (async, rst_n=0):
  - div counter, hcount and vcount = 0
  - hsync = vsync = 1, de = 0, r = g = b = 0, frame_start = 0
  - avga = FB_BASE
- pix_tick: asserted when en=1 and div == CLK_DIV-1. div counts 0..CLK_DIV-1 while en=1 and holds when en=0. CLK_DIV=1 gives pix_tick every en cycle.
- Counters on pix_tick:
  - hcount increments, wrapping at H_TOTAL-1 (799) to 0.
  - On that wrap, vcount increments, wrapping at V_TOTAL-1 (524) to 0.
- Address generation is combinational from the current counters:
  - fx = hcount >> SCALE_LOG2, fy = vcount >> SCALE_LOG2
  - in_img = (fx < IMG_W) && (fy < IMG_H) && hcount < H_ACTIVE && vcount < V_ACTIVE
  - avga = FB_BASE + fy*IMG_W + fx when in_img, else FB_BASE (parked, never out of range)
  - Arithmetic is 32-bit unsigned; the multiply is by a constant.
- Output register updates only on pix_tick, from the current counters, giving one pixel of latency aligned across all outputs:
  - hsync = 0 when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vsync = 0 when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491)
  - de = (hcount < H_ACTIVE) && (vcount < V_ACTIVE)
  - r = g = b = rdvga[7:0] when in_img; 0 (black border) otherwise, including blanking
- frame_start: registered, 1 for exactly one clk on the pix_tick at which the counters wrap from (799,524) to (0,0). 0 otherwise.
- en deassert mid-line: counters, div and all outputs hold their values; the scan resumes from the same point.
- Reset mid-frame returns immediately to the reset values; the scan restarts at (0,0) on release.
- Memory writes during scan-out are not arbitrated; a pixel shows whichever byte is present on its read cycle (tearing is acceptable).

Test Plan:
- Reset, CLK_DIV=2, en=1 -> pix_tick every 2nd clk; hsync low for exactly 96 ticks starting at output of hcount=656; line period 800 ticks = 1600 clk.
- Run a full frame -> vsync low for 2 lines (hcount-driven output during lines 490-491); frame_start high one clk every 800*525 ticks; de high for 640x480 = 307200 ticks per frame.
- Memory model with byte[FB_BASE + y*16 + x] = x*16+y -> screen pixel (hcount=17, vcount=9) maps to fx=2, fy=1, avga=274; the next tick outputs r=g=b=0x21, de=1.
- Screen pixel (hcount=200, vcount=50), outside the 128x128 image -> avga=256, r=g=b=0, de=1; hcount=700 -> de=0, rgb=0.
- Drop en for 37 clk at hcount=300 -> all outputs frozen; after re-enable the next tick hcount=301 with no skipped or duplicated pixel.
- Assert rst_n=0 asynchronously mid-line (no clk edge) -> hsync=vsync=1, de=0, rgb=0, avga=256 immediately; after release the first frame_start arrives after exactly one full frame.
